multi_seg_scan: RTL and testbench

Parametrised N-digit multiplexed seven-segment display driver, the successor to our fixed four-digit scanner. It scans any digit count from 2 to 8 at a programmable refresh rate and decodes one 4-bit hex value per digit. It adds per-digit decimal points, per-digit blanking, leading-zero suppression and PWM brightness control. It sits between the datapath's display registers and the board's common-anode display pins, with all outputs registered.

---
 rtl/multi_seg_scan.sv | 135 +++++++++++++
 tb/tb_multi_seg_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_seg_scan.sv
// multi_seg_scan
//   Multiplexed N-digit seven-segment driver for common-anode displays.
//   Scans NUM_DIGITS digits, each for REFRESH_DIV clocks. Each digit is decoded
//   from a 4-bit hex value. The driver adds per-digit decimal points, forced
//   blanking, leading-zero suppression and PWM brightness. All outputs are
//   registered, with one cycle of latency from counters and inputs.
//
// Ports
//   clk          system clock (rising edge)
//   reset        synchronous active-high reset
//   digits       4*NUM_DIGITS hex values, digit 0 in bits [3:0] (rightmost)
//   dp_in        per-digit decimal point request, 1 = lit
//   blank        per-digit forced blank, 1 = dark
//   lz_suppress  1 = blank leading zero digits (digit 0 always shown)
//   brightness   PWM duty; digit lit while pwm <= brightness
//   seg          active-low segments {g,f,e,d,c,b,a}
//   dp           active-low decimal point
//   an           active-low digit anodes, an[i] drives digit i
//   frame_tick   one-cycle pulse aligned with the first output of digit 0
module multi_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DIM_BITS    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
    input  logic [DIM_BITS-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]    pre_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [DIM_BITS-1:0] pwm_reg;
    logic                wrap_reg;

    logic [3:0]            digit_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:1] digit_zero;
    logic [NUM_DIGITS-1:0] suppressed;

    // Digit i is suppressed only when it and every digit above it are zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = digits[4*gi +: 4];
            if (gi == 0) begin : g_first
                assign suppressed[gi] = 1'b0;
            end else begin : g_upper
                assign digit_zero[gi] = (digits[4*gi +: 4] == 4'h0);
                assign suppressed[gi] = lz_suppress && (&digit_zero[NUM_DIGITS-1:gi]);
            end
        end
    endgenerate

    logic [3:0]            cur_digit;
    logic                  visible;
    logic [6:0]            seg_dec;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    always_comb begin
        cur_digit = digit_arr[idx_reg];
        visible   = !blank[idx_reg] && !suppressed[idx_reg] && (pwm_reg <= brightness);

        seg_dec = 7'h7F;
        case (cur_digit)
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b0000011;
            4'hC: seg_dec = 7'b1000110;
            4'hD: seg_dec = 7'b0100001;
            4'hE: seg_dec = 7'b0000110;
            4'hF: seg_dec = 7'b0001110;
            default: seg_dec = 7'h7F;
        endcase

        seg_next = 7'h7F;
        dp_next  = 1'b1;
        an_next  = '1;
        if (visible) begin
            seg_next = seg_dec;
            dp_next  = ~dp_in[idx_reg];
            an_next  = ~(NUM_DIGITS'(1) << idx_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg    <= '0;
            idx_reg    <= '0;
            pwm_reg    <= '0;
            wrap_reg   <= 1'b0;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            pwm_reg <= pwm_reg + DIM_BITS'(1);
            if (pre_reg == PRE_LAST) begin
                pre_reg <= '0;
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
            end else begin
                pre_reg <= pre_reg + PRE_W'(1);
            end
            // The wrap is seen one edge before digit 0 reaches the outputs;
            // delaying it once lines frame_tick up with the first digit-0 output.
            wrap_reg   <= (pre_reg == PRE_LAST) && (idx_reg == IDX_LAST);
            frame_tick <= wrap_reg;
            seg        <= seg_next;
            dp         <= dp_next;
            an         <= an_next;
        end
    end

endmodule

// File: tb/tb_multi_seg_scan.sv
module tb_multi_seg_scan;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int DB  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*N-1:0]  digits;
    logic [N-1:0]    dp_in;
    logic [N-1:0]    blank;
    logic            lz_suppress;
    logic [DB-1:0]   brightness;
    logic [6:0]      seg;
    logic            dp;
    logic [N-1:0]    an;
    logic            frame_tick;

    always #5 clk = ~clk;

    multi_seg_scan #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(DIV),
        .DIM_BITS   (DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank      (blank),
        .lz_suppress(lz_suppress),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
        logic         ft;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   t_model  = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always @(posedge clk) begin
        exp_t e;
        int   idx;
        int   pwm;
        bit   sup;
        bit   vis;
        logic [3:0] dval;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.an  = {N{1'b1}};
        e.ft  = 1'b0;
        if (reset) begin
            t_model = 0;
        end else begin
            idx = (t_model / DIV) % N;
            pwm = t_model % (1 << DB);
            sup = 1'b0;
            if (lz_suppress && idx >= 1) begin
                sup = 1'b1;
                for (int j = idx; j < N; j++)
                    if (digits[4*j +: 4] != 4'h0) sup = 1'b0;
            end
            vis = !blank[idx] && !sup && (pwm <= int'(brightness));
            if (vis) begin
                dval = digits[4*idx +: 4];
                e.seg = hex_tab[dval];
                e.dp  = ~dp_in[idx];
                e.an  = {N{1'b1}};
                e.an[idx] = 1'b0;
            end
            e.ft = (t_model > 0) && (t_model % (N*DIV) == 0);
            t_model++;
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({seg, dp, an, frame_tick} !== e) begin
                failures++;
                $display("FAIL outputs @%0t: got seg=%b dp=%b an=%b ft=%b, expected seg=%b dp=%b an=%b ft=%b",
                         $time, seg, dp, an, frame_tick, e.seg, e.dp, e.an, e.ft);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_direct(input string name, input exp_t e);
        checks++;
        if ({seg, dp, an, frame_tick} !== e) begin
            failures++;
            $display("FAIL %s @%0t: got seg=%b dp=%b an=%b ft=%b, expected seg=%b dp=%b an=%b ft=%b",
                     name, $time, seg, dp, an, frame_tick, e.seg, e.dp, e.an, e.ft);
        end else begin
            $display("PASS %s @%0t: seg=%b dp=%b an=%b ft=%b",
                     name, $time, seg, dp, an, frame_tick);
        end
    endtask

    task automatic phase_done(input string name);
        $display("phase %s complete: checks=%0d failures=%0d", name, checks, failures);
    endtask

    initial begin
        exp_t rst_e;
        exp_t d0_e;
        rst_e = '{seg: 7'h7F, dp: 1'b1, an: {N{1'b1}}, ft: 1'b0};
        d0_e  = '{seg: 7'b1000000, dp: 1'b1, an: 4'b1110, ft: 1'b0};

        reset       = 1'b1;
        digits      = 16'h0000;
        dp_in       = '0;
        blank       = '0;
        lz_suppress = 1'b0;
        brightness  = 2'd3;
        for (int c = 0; c < 3; c++) begin
            run(1);
            check_direct("reset_hold", rst_e);
        end
        reset = 1'b0;
        run(1);
        check_direct("reset_release", d0_e);
        phase_done("reset");

        digits = 16'h1234;
        run(39);
        phase_done("scan_order");

        digits      = 16'h0050;
        lz_suppress = 1'b1;
        run(16);
        digits = 16'h0000;
        run(16);
        phase_done("leading_zeros");

        digits      = 16'h89AB;
        lz_suppress = 1'b0;
        blank       = 4'b0100;
        dp_in       = 4'b0001;
        run(16);
        phase_done("blank_dp");

        blank      = '0;
        dp_in      = '0;
        digits     = 16'hCDEF;
        brightness = 2'd1;
        run(16);
        brightness = 2'd0;
        run(16);
        brightness = 2'd3;
        phase_done("brightness");

        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(10);
        reset = 1'b1;
        run(1);
        check_direct("reset_mid_scan", rst_e);
        reset = 1'b0;
        run(12);
        phase_done("reset_mid_scan");

        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0)
                digits = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) dp_in = N'($urandom);
            if ($urandom_range(0, 9) == 0) blank = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 11) == 0) lz_suppress = 1'($urandom);
            if ($urandom_range(0, 11) == 0) brightness = DB'($urandom);
            reset = ($urandom_range(0, 79) == 0);
            run(1);
        end
        reset = 1'b0;
        run(4);
        phase_done("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
